// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses, cause codes,
// mstatus/mip bit positions and the sequencer state encoding.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    // Low exception-code nibble; width-independent form of the causes above.
    localparam logic [3:0]  CODE_MEI  = 4'd11;
    localparam logic [3:0]  CODE_MTI  = 4'd7;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int MIP_MTIP = 7;
    localparam int MIP_MEIP = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE_EPC,
        ST_SAVE_CAUSE,
        ST_SAVE_STATUS,
        ST_TRAP_JUMP,
        ST_RET_STATUS,
        ST_RET_JUMP
    } state_e;

endpackage

// File: rtl/irq_pending.sv
// Pending latches for the timer and external interrupts, eligibility masking and
// external-over-timer priority selection.
module irq_pending
    import trap_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          t_intr_i,
    input  logic          e_intr_i,
    input  logic          mtie_i,
    input  logic          meie_i,
    input  logic          en_i,
    output logic          take_o,
    output logic [DW-1:0] cause_o,
    output logic [1:0]    clr_o,
    output logic          pend_t_o,
    output logic          pend_e_o
);

    // Index 0 is the timer source, index 1 the external source.
    logic       pend_q [2];
    logic [1:0] set_w;
    logic       take_t;
    logic       take_e;

    assign set_w  = {e_intr_i, t_intr_i};
    assign take_t = pend_q[0] & mtie_i;
    assign take_e = pend_q[1] & meie_i;
    assign take_o = (take_e | take_t) & en_i;
    assign clr_o  = {take_o & take_e, take_o & ~take_e & take_t};

    always_comb begin
        cause_o       = '0;
        cause_o[DW-1] = 1'b1;
        cause_o[3:0]  = take_e ? CODE_MEI : CODE_MTI;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pend
            // A new pulse in the same cycle as the clear keeps the source pending.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) pend_q[gi] <= 1'b0;
                else       pend_q[gi] <= set_w[gi] | (pend_q[gi] & ~clr_o[gi]);
            end
        end
    endgenerate

    assign pend_t_o = pend_q[0];
    assign pend_e_o = pend_q[1];

endmodule

// File: rtl/irq_trap_ctrl.sv
// Trap sequencer: takes interrupts, writes mepc/mcause/mstatus through the single CSR
// port one per cycle, redirects fetch to the handler and performs the mret return.
module irq_trap_ctrl
    import trap_pkg::*;
#(
    parameter int DW    = 32,
    parameter int ADDRW = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             t_intr_i,
    input  logic             e_intr_i,
    input  logic [DW-1:0]    mstatus_i,
    input  logic [DW-1:0]    mie_i,
    input  logic [DW-1:0]    mtvec_i,
    input  logic [DW-1:0]    mepc_i,
    input  logic [DW-1:0]    pc_i,
    input  logic             pipe_ready_i,
    input  logic             is_mret_i,
    output logic             csr_we_o,
    output logic [ADDRW-1:0] csr_addr_o,
    output logic [DW-1:0]    csr_wdata_o,
    output logic [DW-1:0]    mip_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic             redirect_o,
    output logic [DW-1:0]    redirect_pc_o,
    output logic             busy_o
);

    state_e            state_q;
    logic [DW-1:0]     epc_q;
    logic [DW-1:0]     cause_q;
    logic              csr_we_q;
    logic [ADDRW-1:0]  csr_addr_q;
    logic [DW-1:0]     csr_wdata_q;
    logic              flush_q;
    logic              redirect_q;

    logic              take;
    logic [DW-1:0]     take_cause;
    logic [1:0]        take_clr;
    logic              pend_t;
    logic              pend_e;
    logic              irq_en;
    logic [DW-1:0]     trap_status;
    logic [DW-1:0]     ret_status;
    logic [DW-1:0]     vec_base;
    logic [DW-1:0]     trap_target;
    logic              unused_inputs;

    assign irq_en = mstatus_i[MSTATUS_MIE] & pipe_ready_i & (state_q == ST_IDLE) & ~is_mret_i;

    irq_pending #(.DW(DW)) u_pending (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .t_intr_i (t_intr_i),
        .e_intr_i (e_intr_i),
        .mtie_i   (mie_i[MIP_MTIP]),
        .meie_i   (mie_i[MIP_MEIP]),
        .en_i     (irq_en),
        .take_o   (take),
        .cause_o  (take_cause),
        .clr_o    (take_clr),
        .pend_t_o (pend_t),
        .pend_e_o (pend_e)
    );

    assign unused_inputs = ^{mie_i, take_clr};

    always_comb begin
        trap_status                                = mstatus_i;
        trap_status[MSTATUS_MPIE]                  = mstatus_i[MSTATUS_MIE];
        trap_status[MSTATUS_MIE]                   = 1'b0;
        trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        ret_status                                 = mstatus_i;
        ret_status[MSTATUS_MIE]                    = mstatus_i[MSTATUS_MPIE];
        ret_status[MSTATUS_MPIE]                   = 1'b1;
        ret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    end

    // Reserved mtvec modes fall back to direct; the vectored add wraps naturally.
    assign vec_base    = {mtvec_i[DW-1:2], 2'b00};
    assign trap_target = (mtvec_i[1:0] == 2'b01)
                       ? vec_base + DW'({cause_q[3:0], 2'b00})
                       : vec_base;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            epc_q       <= '0;
            cause_q     <= '0;
            csr_we_q    <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
        end else begin
            csr_we_q    <= 1'b0;
            csr_addr_q  <= '0;
            csr_wdata_q <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (is_mret_i) begin
                        state_q     <= ST_RET_STATUS;
                        epc_q       <= mepc_i;
                        flush_q     <= 1'b1;
                        csr_we_q    <= 1'b1;
                        csr_addr_q  <= ADDRW'(CSR_MSTATUS);
                        csr_wdata_q <= ret_status;
                    end else if (take) begin
                        state_q     <= ST_SAVE_EPC;
                        epc_q       <= pc_i;
                        cause_q     <= take_cause;
                        flush_q     <= 1'b1;
                        csr_we_q    <= 1'b1;
                        csr_addr_q  <= ADDRW'(CSR_MEPC);
                        csr_wdata_q <= pc_i;
                    end
                end
                ST_SAVE_EPC: begin
                    state_q     <= ST_SAVE_CAUSE;
                    csr_we_q    <= 1'b1;
                    csr_addr_q  <= ADDRW'(CSR_MCAUSE);
                    csr_wdata_q <= cause_q;
                end
                ST_SAVE_CAUSE: begin
                    state_q     <= ST_SAVE_STATUS;
                    csr_we_q    <= 1'b1;
                    csr_addr_q  <= ADDRW'(CSR_MSTATUS);
                    csr_wdata_q <= trap_status;
                end
                ST_SAVE_STATUS: begin
                    state_q    <= ST_TRAP_JUMP;
                    redirect_q <= 1'b1;
                end
                ST_RET_STATUS: begin
                    state_q    <= ST_RET_JUMP;
                    redirect_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign csr_we_o      = csr_we_q;
    assign csr_addr_o    = csr_addr_q;
    assign csr_wdata_o   = csr_wdata_q;
    assign flush_o       = flush_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = !redirect_q                ? '0
                         : (state_q == ST_RET_JUMP)   ? epc_q
                         :                              trap_target;
    assign busy_o        = (state_q != ST_IDLE);
    assign stall_o       = (state_q != ST_IDLE);

    always_comb begin
        mip_o           = '0;
        mip_o[MIP_MTIP] = pend_t;
        mip_o[MIP_MEIP] = pend_e;
    end

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Randomised and directed bench for irq_trap_ctrl: a transaction-level model predicts
// CSR writes and redirects into a scoreboard that a negedge monitor drains.
module tb_irq_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        t_intr = 1'b0, e_intr = 1'b0;
    logic [31:0] mstatus_in = '0, mie_in = '0, mtvec_in = '0, mepc_in = '0, pc_in = '0;
    logic        pipe_ready = 1'b0, is_mret = 1'b0;
    logic        csr_we, flush, redirect, stall, busy;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, mip, redirect_pc;

    irq_trap_ctrl #(.DW(32), .ADDRW(12)) dut (
        .clk_i(clk), .rst_i(rst), .t_intr_i(t_intr), .e_intr_i(e_intr),
        .mstatus_i(mstatus_in), .mie_i(mie_in), .mtvec_i(mtvec_in), .mepc_i(mepc_in),
        .pc_i(pc_in), .pipe_ready_i(pipe_ready), .is_mret_i(is_mret),
        .csr_we_o(csr_we), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata), .mip_o(mip),
        .stall_o(stall), .flush_o(flush), .redirect_o(redirect),
        .redirect_pc_o(redirect_pc), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          redir;
        logic [11:0] addr;
        logic [31:0] data;
        int          edge_no;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          passes = 0;

    // Reference model: pending flags, remaining busy edges, and an emulated mstatus register.
    bit          m_pend_t = 0, m_pend_e = 0;
    int          m_busy = 0;
    int          edge_n = 0;
    bit          m_flush = 0;
    logic [31:0] mst = '0, mie = '0, mtvec = '0, mepc = '0, pc = '0;
    logic [31:0] mst_new = '0;
    bit          mst_upd = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %08h expected %08h (edge %0d)", name, act, req, edge_n);
    endtask

    function automatic logic [31:0] on_trap(logic [31:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
    endfunction

    function automatic logic [31:0] on_ret(logic [31:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1880 | (m[7] ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [31:0] handler_pc(logic [31:0] tv, logic [31:0] cause);
        logic [31:0] base;
        base = tv & ~32'h3;
        if ((tv & 32'h3) == 32'h1) return base + 32'd4 * (cause & 32'hF);
        return base;
    endfunction

    // One clock of stimulus; the model advances on the same edge the DUT samples.
    task automatic step(bit t, bit e, bit mret, bit rdy);
        bit          ext;
        logic [31:0] cause;
        @(negedge clk);
        if (m_busy == 0 && mst_upd) begin
            mst     = mst_new;
            mst_upd = 0;
        end
        t_intr = t; e_intr = e; is_mret = mret; pipe_ready = rdy;
        mstatus_in = mst; mie_in = mie; mtvec_in = mtvec; mepc_in = mepc; pc_in = pc;
        @(posedge clk);
        edge_n++;
        m_flush = 0;
        if (m_busy > 0) begin
            m_busy--;
        end else if (mret) begin
            sb_q.push_back('{0, 12'h300, on_ret(mst), edge_n});
            sb_q.push_back('{1, 12'h000, mepc, edge_n + 1});
            mst_new = on_ret(mst); mst_upd = 1;
            m_busy = 2; m_flush = 1;
        end else if (mst[3] && rdy && ((m_pend_e && mie[11]) || (m_pend_t && mie[7]))) begin
            ext   = m_pend_e && mie[11];
            cause = ext ? 32'h8000_000B : 32'h8000_0007;
            if (ext) m_pend_e = 0; else m_pend_t = 0;
            sb_q.push_back('{0, 12'h341, pc, edge_n});
            sb_q.push_back('{0, 12'h342, cause, edge_n + 1});
            sb_q.push_back('{0, 12'h300, on_trap(mst), edge_n + 2});
            sb_q.push_back('{1, 12'h000, handler_pc(mtvec, cause), edge_n + 3});
            mst_new = on_trap(mst); mst_upd = 1;
            m_busy = 4; m_flush = 1;
        end
        if (t) m_pend_t = 1;
        if (e) m_pend_e = 1;
        #1;
        check("mip", mip, (32'(m_pend_e) << 11) | (32'(m_pend_t) << 7));
        check("flush", 32'(flush), 32'(m_flush));
        check("busy", 32'(busy), 32'(m_busy != 0));
        check("stall", 32'(stall), 32'(m_busy != 0));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    task automatic set_cfg(logic [31:0] s, logic [31:0] ie, logic [31:0] tv,
                           logic [31:0] ep, logic [31:0] p);
        mst = s; mst_upd = 0; mie = ie; mtvec = tv; mepc = ep; pc = p;
    endtask

    // Monitor: every cycle with a write or redirect must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (csr_we || redirect)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_out: we=%0b addr=%03h data=%08h redir=%0b pc=%08h expected nothing (edge %0d)",
                             csr_we, csr_addr, csr_wdata, redirect, redirect_pc, edge_n);
                end else begin
                    e = sb_q.pop_front();
                    check("kind_redirect", 32'(redirect), 32'(e.redir));
                    check("kind_we", 32'(csr_we), 32'(!e.redir));
                    if (e.redir) begin
                        check("redirect_pc", redirect_pc, e.data);
                    end else begin
                        check("csr_addr", 32'(csr_addr), 32'(e.addr));
                        check("csr_wdata", csr_wdata, e.data);
                    end
                    check("timing_edge", edge_n, e.edge_no);
                    $display("txn edge=%0d %s addr=%03h data=%08h", edge_n,
                             e.redir ? "redirect" : "csr_wr", e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #12;
        check("rst_csr_we", 32'(csr_we), 0);
        check("rst_csr_addr", 32'(csr_addr), 0);
        check("rst_csr_wdata", csr_wdata, 0);
        check("rst_mip", mip, 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_redirect", 32'(redirect), 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk); #2 rst = 1'b0;

        // Timer trap, direct mode.
        set_cfg(32'h8, 32'h80, 32'h200, 32'h0, 32'h100);
        step(1, 0, 0, 1);
        idle(6);

        // Simultaneous pulses, vectored: external first, timer only after mret.
        set_cfg(32'h8, 32'h880, 32'h201, 32'h0, 32'h300);
        step(1, 1, 0, 1);
        idle(8);
        check("timer_still_pending", mip, 32'h80);
        mepc = 32'h300;
        step(0, 0, 1, 1);
        idle(8);

        // Global disable holds the external interrupt pending.
        set_cfg(32'h1880, 32'h800, 32'h400, 32'h0, 32'h500);
        step(0, 1, 0, 1);
        idle(20);
        mst = 32'h1888;
        idle(6);

        // Plain mret.
        set_cfg(32'h1880, 32'h0, 32'h400, 32'h104, 32'h600);
        step(0, 0, 1, 1);
        idle(3);

        // mret beats a simultaneously eligible interrupt; trap follows RET_JUMP.
        set_cfg(32'h88, 32'h80, 32'h700, 32'h500, 32'h400);
        step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        idle(8);

        // Reset in SAVE_CAUSE aborts the sequence with no redirect.
        set_cfg(32'h8, 32'h880, 32'h200, 32'h0, 32'h800);
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_csr_we", 32'(csr_we), 0);
        check("abort_redirect", 32'(redirect), 0);
        check("abort_redirect_pc", redirect_pc, 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_mip", mip, 0);
        sb_q.delete();
        m_pend_t = 0; m_pend_e = 0; m_busy = 0; mst_upd = 0; m_flush = 0;
        @(posedge clk); #2 rst = 1'b0;
        idle(4);

        // Randomised traffic.
        set_cfg(32'h8, 32'h880, 32'h200, 32'h0, 32'h100);
        for (int i = 0; i < 600; i++) begin
            if (m_busy == 0) begin
                pc   = $urandom & ~32'h3;
                mepc = $urandom & ~32'h3;
                if ($urandom_range(0, 7) == 0) mie = $urandom | (32'($urandom_range(0, 3)) << 7);
                if ($urandom_range(0, 7) == 0)
                    mtvec = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 3)))
                                                        : $urandom;
                if ($urandom_range(0, 15) == 0) begin
                    mst = $urandom; mst_upd = 0;
                end
            end
            step($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 12) == 0, $urandom_range(0, 3) != 0);
        end
        mie = 32'h0;
        idle(8);
        check("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/irq_trap_ctrl.md
# irq_trap_ctrl

Trap sequencer between the interrupt sources, the pipeline and the CSR register file. It latches timer and external interrupt pulses and decides when an interrupt is taken. It then drives the single CSR write port for one CSR per cycle (mepc, mcause, mstatus) and redirects fetch to the handler. On `mret` it restores mstatus and returns to mepc. It is the only writer of trap state; software CSR writes are muxed in by the core only when `busy_o`=0.

## Interface
- DW, 32, data/PC width
- ADDRW, 12, CSR address width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- t_intr_i  in  1  timer interrupt pulse (one clk_i cycle)
- e_intr_i  in  1  external interrupt pulse (one clk_i cycle)
- mstatus_i  in  DW  current mstatus (bit3 MIE, bit7 MPIE, bits12:11 MPP)
- mie_i  in  DW  current mie (bit7 MTIE, bit11 MEIE)
- mtvec_i  in  DW  current mtvec (bits1:0 mode, 00 direct, 01 vectored)
- mepc_i  in  DW  current mepc
- pc_i  in  DW  PC of the oldest uncommitted instruction (the resume point)
- pipe_ready_i  in  1  pipeline is at an interruptible boundary
- is_mret_i  in  1  an mret is committing this cycle
- csr_we_o  out  1  CSR write strobe
- csr_addr_o  out  ADDRW  CSR write address
- csr_wdata_o  out  DW  CSR write data
- mip_o  out  DW  pending view: bit7 = timer pending, bit11 = external pending, others 0
- stall_o  out  1  hold fetch/decode; high in every state except IDLE
- flush_o  out  1  one-cycle flush of in-flight instructions
- redirect_o  out  1  one-cycle PC redirect strobe
- redirect_pc_o  out  DW  redirect target, valid when redirect_o=1
- busy_o  out  1  state != IDLE

## Operation
- Pending latches pend_t and pend_e:
  - set by the matching pulse;
  - cleared when the trap for that source is taken;
  - if set and clear happen in the same cycle, set wins.
- Eligibility: take_e = pend_e & mie_i[11]; take_t = pend_t & mie_i[7]. The interrupt is taken when (take_e | take_t) & mstatus_i[3] & pipe_ready_i & state==IDLE & !is_mret_i.
- Priority: external over timer.
  - Cause for external: 32'h8000_000B.
  - Cause for timer: 32'h8000_0007.
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, TRAP_JUMP, RET_STATUS, RET_JUMP.
- On take (IDLE→SAVE_EPC), in the same edge: capture pc_i into epc_q, capture the cause into cause_q, clear the chosen pending bit. flush_o=1 in the first SAVE_EPC cycle.
- SAVE_EPC: write 0x341 ← epc_q, then go to SAVE_CAUSE.
- SAVE_CAUSE: write 0x342 ← cause_q, then go to SAVE_STATUS.
- SAVE_STATUS: write 0x300 ← mstatus_i with MPIE=MIE, MIE=0, MPP=2'b11, then go to TRAP_JUMP.
- TRAP_JUMP: redirect_o=1, then go to IDLE.
  - Direct mode: target = {mtvec_i[DW-1:2],2'b00}.
  - Vectored mode: target = that base + 4*cause_q[3:0]. The add wraps modulo 2^DW.
- mret: IDLE & is_mret_i → RET_STATUS. In the same edge, flush_o=1 and mepc_i is captured into epc_q. mret has priority over a simultaneous interrupt.
- RET_STATUS: write 0x300 ← mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b11, then go to RET_JUMP.
- RET_JUMP: redirect_o=1 with target epc_q, then go to IDLE. A pending interrupt may be taken from IDLE in the next cycle.
- is_mret_i and pulses arriving while busy: mret is ignored (the pipeline is stalled). Pulses still set the pending latches.
- mstatus_i[3]=0: interrupts stay pending indefinitely; nothing is dropped.

## Timing
- Reset values: all outputs 0, state IDLE, pend_t=pend_e=0, epc_q=cause_q=0. Reset asserted mid-sequence aborts immediately, with no partial redirect.
- Pulse sampled at edge k → mip_o bit visible after k.
- Earliest take is edge k+1. Writes occur in cycles k+1, k+2, k+3; redirect in cycle k+4. Trap latency is 4 cycles after the take edge.
- mret sequence: mstatus write in the cycle after the commit edge, redirect one cycle later.
- Exactly one CSR write per cycle. csr_we_o is 0 in IDLE, TRAP_JUMP and RET_JUMP.
- All outputs are registered except redirect_pc_o, which is combinational from mtvec_i/epc_q while redirect_o=1.

## Structure
- Package trap_pkg holds:
  - CSR addresses (MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MIP 0x344);
  - cause constants;
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11);
  - mip bit positions (MTIP 7, MEIP 11);
  - the FSM state enum.
- Sub-module irq_pending holds the latches, the eligibility mask and the priority encoder. It outputs take, cause and clear.

## Test plan
- Timer pulse, mie=0x80, mstatus=0x8, pc_i=0x100, mtvec=0x200 → csr writes 0x341←0x100, 0x342←0x80000007, 0x300←0x1880; redirect to 0x200 four cycles after the take edge; mip_o bit7 clears.
- Timer and external pulses in the same cycle, vectored mtvec=0x201 → external taken first with redirect 0x22C; timer stays pending and is taken only after the handler's mret.
- mstatus MIE=0 with external pending → no writes and no redirect for 20 cycles; set MIE=1 → trap taken the next cycle.
- mret with mepc_i=0x104, mstatus=0x1880 → write 0x300←0x1888, then redirect to 0x104.
- is_mret_i together with an eligible interrupt → mret sequence completes first; trap entry starts in the cycle after RET_JUMP with epc=pc_i at that point.
- rst_i asserted during SAVE_CAUSE → all outputs 0 immediately; no redirect; pending bits cleared.
